// File: rtl/hazard_detection_unit.sv
// Pipeline stall/flush controller: load-use, ID-branch operand and mul/div EX occupancy hazards.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IfIdRs,
    input  logic [4:0]       IfIdRt,
    input  logic             IfIdUsesRt,
    input  logic             IdIsBranch,
    input  logic             BranchTaken,
    input  logic             IdExMemRead,
    input  logic             IdExRegWrite,
    input  logic [4:0]       IdExDst,
    input  logic             IdExMulDiv,
    input  logic             ExMemMemRead,
    input  logic [4:0]       ExMemDst,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IdExWrite,
    output logic             IdExBubble,
    output logic             ExMemBubble,
    output logic             IfIdFlush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 2);

    generate
        if (MULDIV_LAT < 2) begin : g_bad_lat
            $error("hazard_detection_unit: MULDIV_LAT must be 2 or more");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Register r is a live source of the instruction in ID (r0 never creates a dependency).
    function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    logic load_use_c, br_ex_c, br_mem_c, haz_c;

    always_comb begin
        load_use_c = IdExMemRead && src_match(IdExDst, IfIdRs, IfIdRt, IfIdUsesRt);
        br_ex_c    = IdIsBranch && IdExRegWrite && src_match(IdExDst, IfIdRs, IfIdRt, IfIdUsesRt);
        br_mem_c   = IdIsBranch && ExMemMemRead && src_match(ExMemDst, IfIdRs, IfIdRt, IfIdUsesRt);
        haz_c      = load_use_c || br_ex_c || br_mem_c;
    end

    // State and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PcWrite     = 1'b1;
        IfIdWrite   = 1'b1;
        IdExWrite   = 1'b1;
        IdExBubble  = 1'b0;
        ExMemBubble = 1'b0;
        IfIdFlush   = 1'b0;
        Busy        = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (IdExMulDiv) begin
                    PcWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    IdExWrite   = 1'b0;
                    ExMemBubble = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_MULDIV;
                end else if (haz_c) begin
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExBubble = 1'b1;
                end else if (BranchTaken) begin
                    IfIdFlush = 1'b1;
                end
            end
            ST_MULDIV: begin
                Busy = 1'b1;
                if (cnt_q != '0) begin
                    PcWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    IdExWrite   = 1'b0;
                    ExMemBubble = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                end else begin
                    // Release cycle: the mul/div leaves EX, so only ID hazards apply.
                    state_d = ST_RUN;
                    if (haz_c) begin
                        PcWrite    = 1'b0;
                        IfIdWrite  = 1'b0;
                        IdExBubble = 1'b1;
                    end else if (BranchTaken) begin
                        IfIdFlush = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // During reset every stage loads a clean bubble.
        if (reset) begin
            PcWrite     = 1'b1;
            IfIdWrite   = 1'b1;
            IdExWrite   = 1'b1;
            IdExBubble  = 1'b1;
            ExMemBubble = 1'b1;
            IfIdFlush   = 1'b1;
            Busy        = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters of stalled cycles and IF/ID flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset && !PcWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!reset && IfIdFlush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: vector table plus mul/div, reset and counter sequences.
module tb_hazard_detection_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] IfIdRs, IfIdRt, IdExDst, ExMemDst;
    logic       IfIdUsesRt, IdIsBranch, BranchTaken, IdExMemRead, IdExRegWrite;
    logic       IdExMulDiv, ExMemMemRead;

    logic        pc1, ifid1, idex1, idexb1, exmemb1, flush1, busy1;
    logic        pc2, ifid2, idex2, idexb2, exmemb2, flush2, busy2;
    logic [15:0] stall1, flushc1;
    logic [2:0]  stall2, flushc2;

    hazard_detection_unit #(.MULDIV_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdUsesRt(IfIdUsesRt),
        .IdIsBranch(IdIsBranch), .BranchTaken(BranchTaken),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExDst(IdExDst),
        .IdExMulDiv(IdExMulDiv), .ExMemMemRead(ExMemMemRead), .ExMemDst(ExMemDst),
        .PcWrite(pc1), .IfIdWrite(ifid1), .IdExWrite(idex1), .IdExBubble(idexb1),
        .ExMemBubble(exmemb1), .IfIdFlush(flush1), .Busy(busy1),
        .StallCount(stall1), .FlushCount(flushc1)
    );

    hazard_detection_unit #(.MULDIV_LAT(2), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset),
        .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdUsesRt(IfIdUsesRt),
        .IdIsBranch(IdIsBranch), .BranchTaken(BranchTaken),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExDst(IdExDst),
        .IdExMulDiv(IdExMulDiv), .ExMemMemRead(ExMemMemRead), .ExMemDst(ExMemDst),
        .PcWrite(pc2), .IfIdWrite(ifid2), .IdExWrite(idex2), .IdExBubble(idexb2),
        .ExMemBubble(exmemb2), .IfIdFlush(flush2), .Busy(busy2),
        .StallCount(stall2), .FlushCount(flushc2)
    );

    // {PcWrite, IfIdWrite, IdExWrite, IdExBubble, ExMemBubble, IfIdFlush, Busy}
    wire [6:0] outs1 = {pc1, ifid1, idex1, idexb1, exmemb1, flush1, busy1};
    wire [6:0] outs2 = {pc2, ifid2, idex2, idexb2, exmemb2, flush2, busy2};

    localparam logic [6:0] DEF    = 7'b111_000_0;
    localparam logic [6:0] STALL  = 7'b001_100_0;
    localparam logic [6:0] FLUSH  = 7'b111_001_0;
    localparam logic [6:0] MD_RUN = 7'b000_010_0;
    localparam logic [6:0] MD_BSY = 7'b000_010_1;
    localparam logic [6:0] REL    = 7'b111_000_1;
    localparam logic [6:0] RST    = 7'b111_111_0;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urt, br, tk, exrd, exrw;
        logic [4:0] exdst;
        logic       md, memrd;
        logic [4:0] memdst;
        logic [6:0] exp;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mkv(input logic [4:0] rs, rt, input logic urt, br, tk, exrd, exrw,
                                 input logic [4:0] exdst, input logic md, memrd,
                                 input logic [4:0] memdst, input logic [6:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urt = urt; v.br = br; v.tk = tk; v.exrd = exrd;
        v.exrw = exrw; v.exdst = exdst; v.md = md; v.memrd = memrd; v.memdst = memdst;
        v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        IfIdRs = v.rs; IfIdRt = v.rt; IfIdUsesRt = v.urt; IdIsBranch = v.br;
        BranchTaken = v.tk; IdExMemRead = v.exrd; IdExRegWrite = v.exrw;
        IdExDst = v.exdst; IdExMulDiv = v.md; ExMemMemRead = v.memrd; ExMemDst = v.memdst;
    endtask

    task automatic idle();
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a vector away from the rising edge and sample the combinational outputs.
    task automatic step(input vec_t v);
        @(negedge clk);
        apply(v);
        #1;
    endtask

    int exp_s1, exp_s2, exp_f;

    initial begin
        tbl[0]  = mkv(2, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, STALL);   // load-use on rs
        tbl[1]  = mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);     // bubble now in EX
        tbl[2]  = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, DEF);     // r0 never matches
        tbl[3]  = mkv(1, 3, 0, 0, 0, 1, 0, 3, 0, 0, 0, DEF);     // rt not a source
        tbl[4]  = mkv(1, 3, 1, 0, 0, 1, 0, 3, 0, 0, 0, STALL);   // rt is a source
        tbl[5]  = mkv(5, 0, 0, 1, 1, 0, 1, 5, 0, 0, 0, STALL);   // branch vs EX writer
        tbl[6]  = mkv(5, 0, 0, 1, 1, 0, 0, 0, 0, 1, 5, STALL);   // branch vs MEM load
        tbl[7]  = mkv(5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, FLUSH);   // taken, no dependency
        tbl[8]  = mkv(5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, DEF);     // ALU dep is forwarded
        tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_RUN);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, REL);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_RUN);  // back-to-back mul/div
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[16] = mkv(9, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 7'b111_001_1); // release + taken
        tbl[17] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_RUN);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[19] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY);
        tbl[20] = mkv(7, 0, 0, 1, 1, 0, 1, 7, 1, 0, 0, 7'b001_100_1); // release + hazard
        tbl[21] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        tbl[22] = mkv(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, DEF);     // MEM load, not a branch
        tbl[23] = mkv(1, 6, 1, 1, 1, 0, 1, 6, 0, 0, 0, STALL);   // branch rt vs EX writer

`ifdef HAZARD_PERF_CNT_EN
        exp_s1 = 9; exp_s2 = 7; exp_f = 2;
`else
        exp_s1 = 0; exp_s2 = 0; exp_f = 0;
`endif

        reset = 1'b1;
        idle();
        #1;
        chk("reset_outs", 32'(outs1), 32'(RST));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_outs", 32'(outs1), 32'(DEF));
        chk("post_reset_stall", 32'(stall1), 0);
        chk("post_reset_flush", 32'(flushc1), 0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i]);
            chk($sformatf("vec%0d", i), 32'(outs1), 32'(tbl[i].exp));
        end

        // Reset while MULDIV with cnt=1 aborts the sequence.
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_RUN));
        chk("abort_md_run", 32'(outs1), 32'(MD_RUN));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_BSY));
        chk("abort_md_cnt2", 32'(outs1), 32'(MD_BSY));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_reset", 32'(outs1), 32'(RST));
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        chk("abort_after", 32'(outs1), 32'(DEF));
        chk("abort_stallcnt", 32'(stall1), 0);

        // MULDIV_LAT=2: exactly one stall cycle then release.
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD_RUN));
        chk("lat2_stall", 32'(outs2), 32'(MD_RUN));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, REL));
        chk("lat2_release", 32'(outs2), 32'(REL));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
        chk("lat2_run", 32'(outs2), 32'(DEF));

        // Counters: clear both instances, then 9 load-use stalls and 2 taken branches.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(tbl[0]);
            chk($sformatf("cnt_stall%0d", i), 32'(outs1), 32'(STALL));
        end
        step(tbl[21]);
        chk("stallcnt_16b", 32'(stall1), 32'(exp_s1));
        chk("stallcnt_sat3", 32'(stall2), 32'(exp_s2));
        chk("flushcnt_zero", 32'(flushc1), 0);
        for (int i = 0; i < 2; i++) begin
            step(tbl[7]);
            chk($sformatf("cnt_flush%0d", i), 32'(outs1), 32'(FLUSH));
        end
        step(tbl[21]);
        chk("flushcnt_16b", 32'(flushc1), 32'(exp_f));
        chk("flushcnt_3b", 32'(flushc2), 32'(exp_f));
        chk("stallcnt_hold", 32'(stall2), 32'(exp_s2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Stall/flush controller for the 5-stage pipeline, sitting in ID alongside the EX-stage forwarding logic. It covers the hazards forwarding cannot resolve: load-use, ID-stage branch operand dependencies, and multi-cycle mul/div occupancy of EX. It drives PC / IF-ID / ID-EX write enables, bubble inserts and the IF-ID flush. An FSM with a down-counter tracks mul/div occupancy.

Parameters:
MULDIV_LAT, 4, total cycles a mul/div instruction occupies EX; legal values are 2 and above.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
IfIdRs  in  5  rs of the instruction in ID
IfIdRt  in  5  rt of the instruction in ID
IfIdUsesRt  in  1  ID instruction reads rt as a source
IdIsBranch  in  1  ID instruction is a branch that compares registers in ID
BranchTaken  in  1  branch resolved taken in ID this cycle
IdExMemRead  in  1  EX instruction is a load
IdExRegWrite  in  1  EX instruction writes the register file
IdExDst  in  5  EX destination register (already muxed rt/rd)
IdExMulDiv  in  1  EX instruction is a mul/div
ExMemMemRead  in  1  MEM instruction is a load
ExMemDst  in  5  MEM destination register
PcWrite  out  1  PC load enable
IfIdWrite  out  1  IF/ID load enable
IdExWrite  out  1  ID/EX load enable
IdExBubble  out  1  ID/EX loads zeroed control fields
ExMemBubble  out  1  EX/MEM loads zeroed control fields
IfIdFlush  out  1  IF/ID loads a nop
Busy  out  1  FSM is in MULDIV
StallCount  out  CNT_W  count of stalled cycles
FlushCount  out  CNT_W  count of flushes

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Match terms:
  - m(r) = (r != 0) && (r == IfIdRs || (IfIdUsesRt && r == IfIdRt)).
  - load_use = IdExMemRead && m(IdExDst).
  - br_ex = IdIsBranch && IdExRegWrite && m(IdExDst).
  - br_mem = IdIsBranch && ExMemMemRead && m(ExMemDst).
  - haz = load_use || br_ex || br_mem.
- Default outputs: PcWrite=IfIdWrite=IdExWrite=1; all bubble and flush outputs = 0.
- State RUN, priority order (highest first):
  1. IdExMulDiv=1: freeze PC, IF/ID and ID/EX (three write enables = 0); ExMemBubble=1. Load cnt = MULDIV_LAT-2; next state MULDIV.
  2. haz=1: PcWrite=0, IfIdWrite=0, IdExBubble=1. BranchTaken is ignored this cycle; stay in RUN.
  3. BranchTaken=1: IfIdFlush=1.
- State MULDIV, Busy=1:
  - cnt != 0: same outputs as RUN case 1; cnt decrements.
  - cnt == 0: release. Apply RUN rules 2–3 with IdExMulDiv ignored; next state RUN.
- Net effect: the mul/div stays in EX for exactly MULDIV_LAT cycles, with MULDIV_LAT-1 stall cycles. When MULDIV_LAT=2, the FSM enters MULDIV with cnt=0 and releases on the next cycle.
- Back-to-back mul/div: the second one is detected in RUN on its first EX cycle, giving a fresh MULDIV_LAT-1 stall.
- While reset=1, outputs are forced regardless of state: PcWrite=IfIdWrite=IdExWrite=1, IdExBubble=ExMemBubble=IfIdFlush=1, Busy=0.
- At the reset edge: state=RUN, cnt=0, counters=0.
- Reset mid-MULDIV aborts the sequence; the FSM is in RUN on the next cycle.
- All outputs other than the counters are combinational from state and inputs. State, cnt and counters are registered.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - StallCount increments on every non-reset cycle with PcWrite=0.
  - FlushCount increments on every cycle with IfIdFlush=1 and reset=0.
  - Both counters saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: IdExMemRead=1, IdExDst=2, IfIdRs=2 → exactly one cycle of PcWrite=0, IfIdWrite=0, IdExBubble=1. Next cycle (bubble in EX, IdExMemRead=0) → default outputs.
- Zero register: IdExMemRead=1, IdExDst=0, IfIdRs=0 → no stall. IfIdUsesRt=0, IfIdRt=3, IdExDst=3 load → no stall.
- MULDIV_LAT=4, one-cycle pulse of IdExMulDiv=1 held in ID/EX → cycles 1–3: IdExWrite=0, ExMemBubble=1, PcWrite=0; Busy=1 in cycles 2–3. Cycle 4 → defaults, Busy=1, then RUN. Repeat with MULDIV_LAT=2 → exactly 1 stall cycle.
- Branch: IdIsBranch=1, IfIdRs=5, IdExRegWrite=1, IdExDst=5, BranchTaken=1 → stall, IfIdFlush=0. Next cycle ExMemMemRead=1, ExMemDst=5 → stall again. Third cycle with no match and BranchTaken=1 → IfIdFlush=1, PcWrite=1.
- Reset asserted while in MULDIV with cnt=1 → during reset, all enables and bubbles are 1. After deassertion: Busy=0, RUN, StallCount=0.
- With HAZARD_PERF_CNT_EN and CNT_W=3: 9 load-use stalls → StallCount=7. 2 taken branches → FlushCount=2. Without the macro, both counters read 0.
